// File: rtl/fir_decim_requant.sv
// fir_decim_requant: integrate-and-dump decimator for the FIR output stream.
// Each frame of DECIM accepted samples is summed, arithmetically shifted
// right by SHIFT, saturated to OUT_W bits and pushed into a small output FIFO
// drained through a valid/ready handshake. The filter side is never stalled;
// a result that finds the FIFO full (and no pop on that edge) is dropped.
// Optional macro FIR_DEC_ROUND_EN: round half up before the shift
// (default build truncates toward -inf with no rounding adder).
module fir_decim_requant #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int DECIM      = 4,
    parameter int SHIFT      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [IN_W-1:0]        in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          sat_flag,
    output logic                          drop_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int ACC_W = IN_W + $clog2(DECIM);
    localparam int PW    = $clog2(DECIM);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [PW-1:0] LAST_PH  = PW'(DECIM - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Saturation bounds, held one bit wider than the accumulator so the
    // rounded sum can be compared without overflow.
    localparam logic signed [ACC_W:0] SAT_MAX = $signed((ACC_W+1)'(2**(OUT_W-1) - 1));
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

`ifdef FIR_DEC_ROUND_EN
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND_HALF =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
`endif

    // Rescale a frame sum: round half up (optional) then arithmetic shift.
    function automatic logic signed [ACC_W:0] scale(input logic signed [ACC_W:0] s);
`ifdef FIR_DEC_ROUND_EN
        return (s + RND_HALF) >>> SHIFT;
`else
        return s >>> SHIFT;
`endif
    endfunction

    // True when the scaled value does not fit in OUT_W signed bits.
    function automatic logic is_sat(input logic signed [ACC_W:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    // Clamp the scaled value into the OUT_W signed range.
    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] x);
        if (x > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
        else if (x < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        else                  return x[OUT_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] acc_p0;
    logic [PW-1:0]           phase_p0;
    logic signed [ACC_W:0]   acc_x, in_x, sum_p0, scaled_p0;
    logic signed [OUT_W-1:0] res_p0;
    logic                    sat_p0;
    logic                    last, full, pop, wr_en, drop;

    logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;

    // Stage p0: frame sum including the current sample, scaled and clamped.
    always_comb begin
        acc_x     = {acc_p0[ACC_W-1], acc_p0};
        in_x      = {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
        sum_p0    = acc_x + in_x;
        scaled_p0 = scale(sum_p0);
        res_p0    = saturate(scaled_p0);
        sat_p0    = is_sat(scaled_p0);
    end

    // Push/pop decisions: a full FIFO still accepts a push when it pops on the same edge.
    always_comb begin
        last  = in_valid && (phase_p0 == LAST_PH);
        full  = (count == FULL_CNT);
        pop   = out_valid && out_ready;
        wr_en = last && (!full || pop);
        drop  = last && full && !pop;
    end

    // Integrate-and-dump accumulator and phase; both hold while in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p0   <= '0;
            phase_p0 <= '0;
        end else if (in_valid) begin
            if (phase_p0 == LAST_PH) begin
                acc_p0   <= '0;
                phase_p0 <= '0;
            end else begin
                acc_p0   <= sum_p0[ACC_W-1:0];
                phase_p0 <= phase_p0 + PW'(1);
            end
        end
    end

    // FIFO storage: data only, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= res_p0;
    end

    // FIFO pointers, occupancy and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(pop);
            if (last && sat_p0)
                sat_flag <= 1'b1;
            if (drop)
                drop_flag <= 1'b1;
        end
    end

    // Output view of the FIFO head; forced to zero while empty.
    always_comb begin
        out_valid  = (count != '0);
        out_data   = out_valid ? mem[rd_ptr] : '0;
        fifo_count = count;
    end

endmodule

// File: tb/tb_fir_decim_requant.sv
// Self-checking bench for fir_decim_requant (DECIM=4, SHIFT=2, OUT_W=8, FIFO_DEPTH=4).
// Expected words come from plain integer arithmetic on whole frames
// (sum, floor division by 2**SHIFT, clamp) and a queue standing in for the FIFO.
module tb_fir_decim_requant;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int DECIM = 4;
    localparam int SHIFT = 2;
    localparam int DEPTH = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic signed [IN_W-1:0]    in_data = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic signed [OUT_W-1:0]   out_data;
    logic                      sat_flag;
    logic                      drop_flag;
    logic [$clog2(DEPTH):0]    fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int got[$];

    fir_decim_requant #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DECIM(DECIM), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag), .drop_flag(drop_flag), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Record every word the sink takes (pop happens on the next rising edge).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            got.push_back(int'(out_data));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference arithmetic ----------------
    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int scaled_of(input int sum);
        int s;
        s = sum;
`ifdef FIR_DEC_ROUND_EN
        if (SHIFT > 0) s = s + 2**(SHIFT-1);
`endif
        return floor_div(s, 2**SHIFT);
    endfunction

    function automatic int ref_word(input int sum);
        int s;
        s = scaled_of(sum);
        if (s > 2**(OUT_W-1) - 1) return 2**(OUT_W-1) - 1;
        if (s < -(2**(OUT_W-1)))  return -(2**(OUT_W-1));
        return s;
    endfunction

    function automatic bit ref_sat(input int sum);
        int s;
        s = scaled_of(sum);
        return (s > 2**(OUT_W-1) - 1) || (s < -(2**(OUT_W-1)));
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic send(input logic v, input int d);
        in_valid = v;
        in_data  = IN_W'(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && fifo_count != 0; i++)
            send(1'b0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++; if (out_data !== 8'sd0) begin n_fail++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag got=%b want=0", sat_flag); end
        n_checks++; if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL reset_drop_flag got=%b want=0", drop_flag); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count got=%0d want=0", fifo_count); end
    endtask

    task automatic test_basic();
        int e;
        e = ref_word(1 + 2 + 3 + 4);
        send(1'b1, 1); send(1'b1, 2); send(1'b1, 3);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
        send(1'b1, 4);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b want=1", out_valid); end
        n_checks++; if (out_data !== 8'(e)) begin n_fail++; $display("FAIL basic_data got=%0d want=%0d", out_data, e); end
        n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL basic_sat got=%b want=0", sat_flag); end
        send(1'b0, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got=%b want=0", out_valid); end
    endtask

    task automatic test_saturation();
        int e;
        e = ref_word(4 * 32767);
        repeat (4) send(1'b1, 32767);
        n_checks++; if (out_data !== 8'(e)) begin n_fail++; $display("FAIL sat_pos_data got=%0d want=%0d", out_data, e); end
        n_checks++; if (sat_flag !== ref_sat(4 * 32767)) begin n_fail++; $display("FAIL sat_pos_flag got=%b want=1", sat_flag); end
        send(1'b0, 0);
        e = ref_word(-400);
        repeat (4) send(1'b1, -100);
        n_checks++; if (out_data !== 8'(e)) begin n_fail++; $display("FAIL sat_m100_data got=%0d want=%0d", out_data, e); end
        send(1'b0, 0);
        e = ref_word(4 * -32768);
        repeat (4) send(1'b1, -32768);
        n_checks++; if (out_data !== 8'(e)) begin n_fail++; $display("FAIL sat_neg_data got=%0d want=%0d", out_data, e); end
        send(1'b0, 0);
    endtask

    task automatic test_overflow_drop();
        int e;
        e = ref_word(16);
        out_ready = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            repeat (4) send(1'b1, 4);
            n_checks++;
            if (fifo_count !== 3'((f < DEPTH) ? f : DEPTH)) begin
                n_fail++; $display("FAIL drop_count_f%0d got=%0d want=%0d", f, fifo_count, (f < DEPTH) ? f : DEPTH);
            end
            if (f == 4) begin
                n_checks++; if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL drop_flag_early got=%b want=0", drop_flag); end
            end
        end
        n_checks++; if (drop_flag !== 1'b1) begin n_fail++; $display("FAIL drop_flag got=%b want=1", drop_flag); end
        got.delete();
        out_ready = 1'b1;
        drain(20);
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL drop_drain_count got=%0d want=0", fifo_count); end
        n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL drop_drain_words got=%0d want=4", got.size()); end
        foreach (got[i]) begin
            n_checks++; if (got[i] != e) begin n_fail++; $display("FAIL drop_word%0d got=%0d want=%0d", i, got[i], e); end
        end
    endtask

    task automatic test_full_push_pop();
        int exp_q[$];
        int sum, d;
        do_reset();
        out_ready = 1'b0;
        for (int f = 0; f < 5; f++) begin
            sum = 0;
            for (int k = 0; k < DECIM; k++) begin
                d = int'($signed(16'($urandom)));
                sum += d;
                if (f == 4 && k == DECIM - 1) begin
                    n_checks++; if (fifo_count !== 3'(DEPTH)) begin n_fail++; $display("FAIL fpp_full got=%0d want=%0d", fifo_count, DEPTH); end
                    got.delete();
                    out_ready = 1'b1;
                end
                send(1'b1, d);
            end
            exp_q.push_back(ref_word(sum));
        end
        n_checks++; if (fifo_count !== 3'(DEPTH)) begin n_fail++; $display("FAIL fpp_count got=%0d want=%0d", fifo_count, DEPTH); end
        n_checks++; if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL fpp_drop got=%b want=0", drop_flag); end
        drain(20);
        n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL fpp_words got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++; if (got[i] != exp_q[i]) begin n_fail++; $display("FAIL fpp_order%0d got=%0d want=%0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_gaps();
        int e;
        do_reset();
        out_ready = 1'b1;
        e = ref_word(10);
        for (int k = 1; k <= 4; k++) begin
            send(1'b1, k);
            if (k == 4) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid got=%b want=1", out_valid); end
                n_checks++; if (out_data !== 8'(e)) begin n_fail++; $display("FAIL gaps_data got=%0d want=%0d", out_data, e); end
            end
            send(1'b0, int'($urandom_range(0, 65535)));
            if (k == 3) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_hold got=%b want=0", out_valid); end
            end
        end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL gaps_count got=%0d want=0", fifo_count); end
    endtask

    task automatic test_reset_midframe();
        int e;
        do_reset();
        out_ready = 1'b1;
        e = ref_word(4);
        send(1'b1, 50); send(1'b1, 50);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'sd50;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) send(1'b1, 1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early got=%b want=0", out_valid); end
        send(1'b1, 1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_valid got=%b want=1", out_valid); end
        n_checks++; if (out_data !== 8'(e)) begin n_fail++; $display("FAIL midrst_data got=%0d want=%0d", out_data, e); end
        n_checks++; if (sat_flag !== 1'b0 || drop_flag !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got=%b%b want=00", sat_flag, drop_flag); end
        send(1'b0, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_single got=%b want=0", out_valid); end
    endtask

    task automatic test_random();
        int frame[$];
        int fifo_m[$];
        bit sat_m, drop_m, pop_m, push_m;
        int d, w, sum;
        do_reset();
        sat_m = 0; drop_m = 0; w = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            d = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) != 0) ? 32767 : -32768)
                                            : int'($signed(16'($urandom)));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = IN_W'(d);
            out_ready = ($urandom_range(0, 9) < (((cyc / 100) % 2 != 0) ? 9 : 2));
            pop_m  = (fifo_m.size() > 0) && out_ready;
            push_m = 0;
            if (in_valid) begin
                frame.push_back(d);
                if (frame.size() == DECIM) begin
                    sum = 0;
                    foreach (frame[i]) sum += frame[i];
                    w = ref_word(sum);
                    if (ref_sat(sum)) sat_m = 1;
                    if (fifo_m.size() < DEPTH || pop_m) push_m = 1;
                    else drop_m = 1;
                    frame.delete();
                end
            end
            if (pop_m) void'(fifo_m.pop_front());
            if (push_m) fifo_m.push_back(w);
            @(posedge clk);
            #1;
            n_checks++; if (fifo_count !== 3'(fifo_m.size())) begin n_fail++; $display("FAIL rnd_count c%0d got=%0d want=%0d", cyc, fifo_count, fifo_m.size()); end
            n_checks++; if (out_valid !== (fifo_m.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c%0d got=%b want=%b", cyc, out_valid, fifo_m.size() > 0); end
            if (fifo_m.size() > 0) begin
                n_checks++; if (out_data !== 8'(fifo_m[0])) begin n_fail++; $display("FAIL rnd_data c%0d got=%0d want=%0d", cyc, out_data, fifo_m[0]); end
            end
            n_checks++; if (sat_flag !== sat_m || drop_flag !== drop_m) begin n_fail++; $display("FAIL rnd_flags c%0d got=%b%b want=%b%b", cyc, sat_flag, drop_flag, sat_m, drop_m); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overflow_drop();
        test_full_push_pop();
        test_gaps();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
